// File: rtl/cla_pkg.sv
// Shared types and helpers for the chunked carry-lookahead adder.
// Holds the controller state encoding and the chunk-counter width calculation.
`timescale 1ns/1ps
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ceil(log2(n+1)), never less than 1, so the counter can also hold n itself
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < (n + 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cla_block.sv
// Purely combinational CHUNK-bit carry-lookahead adder slice.
// Every carry is a flat sum of generate/propagate products, with no ripple between bits.
`timescale 1ns/1ps
module cla_block #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             c0,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK-1:0] p;
  logic [CHUNK-1:0] g;
  logic [CHUNK:0]   c;

  // Carry into bit idx+1: any g[j] whose upper propagates all pass, or c0 through every p.
  function automatic logic carry_into(input logic [CHUNK-1:0] pv,
                                      input logic [CHUNK-1:0] gv,
                                      input logic             cv,
                                      input int               idx);
    logic acc;
    logic prod;
    acc = 1'b0;
    for (int j = 0; j <= idx; j++) begin
      prod = gv[j];
      for (int k = j + 1; k <= idx; k++) begin
        prod = prod & pv[k];
      end
      acc = acc | prod;
    end
    prod = cv;
    for (int k = 0; k <= idx; k++) begin
      prod = prod & pv[k];
    end
    return acc | prod;
  endfunction

  assign p    = x ^ y;
  assign g    = x & y;
  assign c[0] = c0;

  genvar gi;
  generate
    for (gi = 0; gi < CHUNK; gi++) begin : g_carry
      assign c[gi+1] = carry_into(p, g, c0, gi);
    end
  endgenerate

  assign s     = p ^ c[CHUNK-1:0];
  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_cla_adder.sv
// Multi-cycle add/subtract unit: one CHUNK-wide lookahead block walks the operands
// a chunk per cycle, with a registered carry linking consecutive chunks.
`timescale 1ns/1ps
module chunked_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK_OK = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCHUNK   = WIDTH / CHUNK_OK;
  localparam int CW       = cnt_width(NCHUNK);

  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK_OK) != 0) begin : g_param_check
      $error("chunked_cla_adder: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
             WIDTH, CHUNK);
    end
  endgenerate

  state_t           state_reg;
  logic [CW-1:0]    k_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] bx_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             done_reg;

  logic [CHUNK-1:0] a_chunk  [NCHUNK];
  logic [CHUNK-1:0] bx_chunk [NCHUNK];
  logic [CHUNK-1:0] blk_x;
  logic [CHUNK-1:0] blk_y;
  logic [CHUNK-1:0] blk_s;
  logic             blk_cout;
  logic             blk_c_msb;

  // Split operands into chunks and splice the block result into the active accumulator slice.
  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign a_chunk[gi]  = a_reg[gi*CHUNK +: CHUNK];
      assign bx_chunk[gi] = bx_reg[gi*CHUNK +: CHUNK];
      assign acc_next[gi*CHUNK +: CHUNK] =
        (k_reg == CW'(gi)) ? blk_s : acc_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  always_comb begin
    blk_x = '0;
    blk_y = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k_reg == CW'(i)) begin
        blk_x = a_chunk[i];
        blk_y = bx_chunk[i];
      end
    end
  end

  cla_block #(
    .CHUNK (CHUNK)
  ) u_cla_block (
    .x     (blk_x),
    .y     (blk_y),
    .c0    (carry_reg),
    .s     (blk_s),
    .cout  (blk_cout),
    .c_msb (blk_c_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      bx_reg    <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_reg     <= a;
            bx_reg    <= sub ? ~b : b;
            carry_reg <= sub ? 1'b1 : cin;
            k_reg     <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          acc_reg   <= acc_next;
          carry_reg <= blk_cout;
          k_reg     <= k_reg + CW'(1);
          // Results become visible only once the top chunk has been added.
          if (k_reg == CW'(NCHUNK - 1)) begin
            sum_reg   <= acc_next;
            cout_reg  <= blk_cout;
            ovf_reg   <= blk_c_msb ^ blk_cout;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ready = (state_reg == IDLE);
  assign done  = done_reg;
  assign sum   = sum_reg;
  assign cout  = cout_reg;
  assign ovf   = ovf_reg;

endmodule

// File: doc/chunked_cla_adder.md
Name: chunked_cla_adder

Overview:
- Parametrised, multi-cycle add/subtract unit for the datapath.
- Processes a WIDTH-bit operation CHUNK bits per cycle through one CHUNK-bit carry-lookahead block.
  - Each block generates p/g, computes carries by lookahead, and forms sum = p XOR c.
  - A registered carry chains consecutive chunks.
- Start/ready/done handshake. Reports carry-out and signed overflow.
- Sits behind the ALU operand registers. It trades latency for area on wide operands.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 4: bits processed per cycle, which is the lookahead block width. 1 <= CHUNK <= WIDTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation. Sampled only when ready=1.
- sub  in  1  0: a+b+cin; 1: a-b, computed as a + ~b + 1 with cin ignored. Sampled with start.
- a  in  WIDTH  operand A. Sampled with start.
- b  in  WIDTH  operand B. Sampled with start.
- cin  in  1  carry-in for add mode. Sampled with start.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse when the result is valid.
- sum  out  WIDTH  registered result. Held until the next operation completes.
- cout  out  1  carry out of bit WIDTH-1. In sub mode, 0 means a borrow occurred.
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: rst high forces state IDLE and clears the internal counter and carry register at once, with no clock needed. Outputs during reset: sum=0, cout=0, ovf=0, done=0, ready=1.
- NCHUNK = WIDTH/CHUNK. The chunk counter is ceil(log2(NCHUNK+1)) bits wide, minimum 1.
- States:
  - IDLE -> RUN on start=1 at edge E0. At E0 the block latches a, bx = sub ? ~b : b, carry = sub ? 1 : cin, and k=0.
  - RUN, edges E1..E_NCHUNK: each edge processes chunk k, i.e. bits [k*CHUNK +: CHUNK]. The cla_block result is written into that slice of the accumulator, carry takes the block's carry-out, then k increments.
  - At the edge that processes k=NCHUNK-1 (E_NCHUNK):
    - state -> DONE;
    - sum is loaded from the completed accumulator;
    - cout is loaded from the final carry;
    - ovf is loaded from the block's MSB carry-in XOR its carry-out;
    - done is registered high.
  - DONE lasts exactly one cycle. The next edge returns to IDLE and clears done.
- Timing: start-to-done latency is NCHUNK cycles, with done visible after E_NCHUNK. Throughput is one operation per NCHUNK+2 cycles.
- ready is combinational from state: 1 in IDLE only.
- start is ignored in RUN and DONE. Operand changes after E0 have no effect.
- sum, cout and ovf change only at DONE entry. Partial results are never visible.
- Arithmetic is modulo 2^WIDTH with no saturation. Carry ripples correctly across any number of chunks.
- If rst asserts mid-RUN, the operation is aborted, no done is produced, and outputs clear immediately.
- CHUNK=WIDTH is legal: a single RUN cycle, latency 1.
- Illegal parameters (WIDTH % CHUNK != 0, or CHUNK < 1) must trigger an elaboration-time $error.

Decomposition:
- Package cla_pkg:
  - state encoding IDLE/RUN/DONE as a 2-bit typedef;
  - a clog2-style helper function for the counter width.
- Sub-module cla_block, parametrised by CHUNK, purely combinational.
  - Inputs: x, y, c0.
  - Outputs: s, cout, c_msb (carry into bit CHUNK-1).
  - Internals: p = x^y, g = x&y, lookahead carries c[i+1] = g[i] | p[i]&c[i] expanded, s = p ^ c.
  - chunked_cla_adder instantiates exactly one cla_block.

Test Plan:
- Reset: assert rst mid-simulation -> immediately ready=1, done=0, sum=0x0000, cout=0, ovf=0.
- WIDTH=16, CHUNK=4, add mode:
  - a=0x1234, b=0x4321, cin=1 -> done exactly 4 cycles after the start edge, sum=0x5556, cout=0, ovf=0. done is high for one cycle and ready returns the cycle after.
  - a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry through all 4 chunks).
  - a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract: sub=1, a=0x0005, b=0x0007, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Protocol: start with a=0x0001, b=0x0001, then pulse start with a=0xAAAA during RUN -> that start is ignored and the result is sum=0x0002. Then assert rst during the next RUN -> no done pulse, outputs cleared, ready=1 asynchronously.
- Parameter sweep: WIDTH=16/CHUNK=16 and WIDTH=12/CHUNK=3, 1000 random operands each with a random sub flag -> every result matches a reference model, and latency equals NCHUNK every time.
